// File: rtl/ets_pkg.sv
// Shared types and constants for the ETS frame writer: FSM states, one-hot
// buffer ids and sticky error bit positions.
package ets_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StWaitTrig,
    StWrite,
    StHandoffReq,
    StHandoffRel
  } ets_state_e;

  localparam logic [2:0] BUF0 = 3'b001;
  localparam logic [2:0] BUF1 = 3'b010;
  localparam logic [2:0] BUF2 = 3'b100;

  localparam int unsigned ErrBadId   = 0;
  localparam int unsigned ErrTimeout = 1;

endpackage

// File: rtl/ets_onehot_bank_decode.sv
// One-hot write buffer id to bank index; valid_o is low for any non-one-hot
// pattern.
module ets_onehot_bank_decode
  import ets_pkg::*;
(
  input  logic [2:0] onehot_i,
  output logic [1:0] bank_o,
  output logic       valid_o
);

  always_comb begin
    bank_o  = 2'd0;
    valid_o = 1'b0;
    unique case (onehot_i)
      BUF0: begin
        bank_o  = 2'd0;
        valid_o = 1'b1;
      end
      BUF1: begin
        bank_o  = 2'd1;
        valid_o = 1'b1;
      end
      BUF2: begin
        bank_o  = 2'd2;
        valid_o = 1'b1;
      end
      default: begin
        bank_o  = 2'd0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ets_frame_writer.sv
// Writes each triggered frame of FRAME_DEPTH samples into the controller's
// current write bank, then hands the buffer off and re-latches the new bank.
module ets_frame_writer
  import ets_pkg::*;
#(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned FRAME_DEPTH     = 1024,
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned HANDOFF_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              trigger,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic [2:0]        w_buffer_id,
  input  logic              w_frame_ready,
  output logic              w_request,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              frame_done,
  output logic              busy,
  output logic [1:0]        err,
  output logic [15:0]       frame_count
);

  localparam int unsigned OffW   = $clog2(FRAME_DEPTH);
  localparam int unsigned CntMax = (SETTLE_CYCLES > HANDOFF_TIMEOUT) ? SETTLE_CYCLES
                                                                     : HANDOFF_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [OffW-1:0] LastOff     = OffW'(FRAME_DEPTH - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(HANDOFF_TIMEOUT - 1);

  ets_state_e        state_q, state_d;
  logic [OffW-1:0]   offset_q, offset_d, off_cur;
  logic [1:0]        bank_q, bank_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              accept;
  logic [1:0]        dec_bank;
  logic              dec_valid;

  ets_onehot_bank_decode u_decode (
    .onehot_i (w_buffer_id),
    .bank_o   (dec_bank),
    .valid_o  (dec_valid)
  );

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    bank_d        = bank_q;
    cnt_d         = '0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_d         = err_q;
    frame_count_d = frame_count_q;
    accept        = 1'b0;
    // The triggering cycle always starts a fresh frame at offset 0.
    off_cur       = (state_q == StWaitTrig) ? '0 : offset_q;

    case (state_q)
      StIdle: begin
        if (arm) state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          if (dec_valid) begin
            bank_d  = dec_bank;
            state_d = StWaitTrig;
          end else begin
            err_d[ErrBadId] = 1'b1;
            state_d         = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitTrig: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (trigger) begin
          state_d = StWrite;
          accept  = s_valid;
        end
      end
      StWrite: begin
        accept = s_valid;
        if (s_valid && offset_q == LastOff) state_d = StHandoffReq;
      end
      StHandoffReq: begin
        if (w_frame_ready) begin
          state_d = StHandoffRel;
        end else if (cnt_q == TimeoutLast) begin
          err_d[ErrTimeout] = 1'b1;
          state_d           = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHandoffRel: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = arm ? StSettle : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StWaitTrig && arm && trigger) offset_d = '0;
    if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = (ADDR_W'(bank_q) << OffW) + ADDR_W'(off_cur);
      mem_wdata_d = s_data;
      offset_d    = off_cur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      offset_q      <= '0;
      bank_q        <= 2'd0;
      cnt_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_q         <= 2'b00;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      bank_q        <= bank_d;
      cnt_q         <= cnt_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_q         <= err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // State-decoded so an asynchronous reset drops the request immediately.
  assign w_request   = (state_q == StHandoffReq);
  assign frame_done  = (state_q == StHandoffRel);
  assign busy        = (state_q != StIdle) && (state_q != StWaitTrig);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign err         = err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ets_frame_writer.sv
// Self-checking bench for ets_frame_writer: a scoreboard queue of expected
// memory writes is filled by the stimulus and drained by a write monitor.
module tb_ets_frame_writer;
  import ets_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned FD = 8;
  localparam int unsigned AW = 12;
  localparam int unsigned SC = 4;
  localparam int unsigned HT = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          arm;
  logic          trigger;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [2:0]    w_buffer_id;
  logic          w_frame_ready;
  logic          w_request;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          frame_done;
  logic          busy;
  logic [1:0]    err;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  ets_frame_writer #(
    .DATA_W          (DW),
    .FRAME_DEPTH     (FD),
    .ADDR_W          (AW),
    .SETTLE_CYCLES   (SC),
    .HANDOFF_TIMEOUT (HT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm           (arm),
    .trigger       (trigger),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .w_buffer_id   (w_buffer_id),
    .w_frame_ready (w_frame_ready),
    .w_request     (w_request),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .frame_done    (frame_done),
    .busy          (busy),
    .err           (err),
    .frame_count   (frame_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_exp;
  int  n_pass   = 0;
  int  n_total  = 0;
  int  n_writes = 0;

  // Write monitor: every mem_we must match the next expected write in order.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        n_writes++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL write_unexpected: got addr %0d data %0h, required no write",
                   mem_addr, mem_wdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mem_addr !== mon_exp.addr || mem_wdata !== mon_exp.data)
            $display("FAIL write_data: got addr %0d data %0h, required addr %0d data %0h",
                     mem_addr, mem_wdata, mon_exp.addr, mon_exp.data);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    arm           = 1'b0;
    trigger       = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    w_frame_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Waits until the block has passed through SETTLE and sits in WAIT_TRIG.
  task automatic wait_armed(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (w_request) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drives one frame; gap > 0 inserts idle cycles before every odd sample.
  task automatic send_frame(input logic [1:0] bank, input int gap, input logic [DW-1:0] base);
    wr_t e;
    for (int i = 0; i < FD; i++) begin
      if (gap > 0 && (i % 2) == 1) begin
        s_valid = 1'b0;
        repeat (gap) tick();
      end
      trigger = (i == 0);
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      e.addr  = AW'(bank) * AW'(FD) + AW'(i);
      e.data  = base + DW'(i);
      exp_q.push_back(e);
      tick();
    end
    trigger = 1'b0;
    s_valid = 1'b0;
  endtask

  // Controller model: ack one cycle, then switch the write buffer two cycles later.
  task automatic handoff(input logic [2:0] next_id, output logic fd, output logic wr,
                         output logic [15:0] fc);
    tick();
    w_frame_ready = 1'b1;
    tick();
    w_frame_ready = 1'b0;
    fd = frame_done;
    wr = w_request;
    tick();
    w_buffer_id = next_id;
    fc = frame_count;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    arm           = 1'b0;
    trigger       = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    w_frame_ready = 1'b0;
    w_buffer_id   = BUF0;
    repeat (2) tick();
    n_total++;
    if ({w_request, mem_we, frame_done, busy} !== 4'b0000)
      $display("FAIL reset_ctrl: got req/we/done/busy %b, required 0000",
               {w_request, mem_we, frame_done, busy});
    else n_pass++;
    n_total++;
    if (mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_mem: got addr %0h data %0h, required 0 0", mem_addr, mem_wdata);
    else n_pass++;
    n_total++;
    if (err !== 2'b00 || frame_count !== 16'd0)
      $display("FAIL reset_status: got err %b count %0d, required 00 0", err, frame_count);
    else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    bit ok;
    int w0;
    logic fd, wr;
    logic [15:0] fc;
    do_reset();
    w_buffer_id = BUF0;
    arm = 1'b1;
    wait_armed(ok);
    n_total++;
    if (!ok) $display("FAIL basic_arm: got not armed, required WAIT_TRIG");
    else n_pass++;
    w0 = n_writes;
    send_frame(2'd0, 0, 16'h0000);
    wait_req(ok);
    n_total++;
    if (!ok) $display("FAIL basic_request: got w_request 0, required 1");
    else n_pass++;
    handoff(BUF2, fd, wr, fc);
    n_total++;
    if (fd !== 1'b1 || wr !== 1'b0)
      $display("FAIL basic_release: got done %b req %b, required 1 0", fd, wr);
    else n_pass++;
    n_total++;
    if (fc !== 16'd1) $display("FAIL basic_count: got %0d, required 1", fc);
    else n_pass++;
    n_total++;
    if (n_writes - w0 != FD || exp_q.size() != 0)
      $display("FAIL basic_writes: got %0d writes %0d pending, required %0d 0",
               n_writes - w0, exp_q.size(), FD);
    else n_pass++;
  endtask

  task automatic test_controller_handoff();
    bit ok;
    int w0;
    logic fd, wr;
    logic [15:0] fc;
    wait_armed(ok);
    n_total++;
    if (!ok) $display("FAIL handoff_rearm: got not armed, required WAIT_TRIG");
    else n_pass++;
    w0 = n_writes;
    send_frame(2'd2, 0, 16'h0100);
    wait_req(ok);
    handoff(BUF2, fd, wr, fc);
    n_total++;
    if (!ok || fd !== 1'b1 || fc !== 16'd2)
      $display("FAIL handoff_done: got req_seen %0d done %b count %0d, required 1 1 2",
               ok, fd, fc);
    else n_pass++;
    n_total++;
    if (n_writes - w0 != FD || exp_q.size() != 0)
      $display("FAIL handoff_writes: got %0d writes %0d pending, required %0d 0",
               n_writes - w0, exp_q.size(), FD);
    else n_pass++;
  endtask

  task automatic test_bank_offset();
    bit ok;
    int w0;
    logic fd, wr;
    logic [15:0] fc;
    wait_armed(ok);
    w0 = n_writes;
    // Samples without a trigger must be dropped.
    s_valid = 1'b1;
    s_data  = 16'hdead;
    repeat (2) tick();
    s_valid = 1'b0;
    send_frame(2'd2, 2, 16'h0200);
    wait_req(ok);
    handoff(BUF2, fd, wr, fc);
    arm = 1'b0;
    n_total++;
    if (!ok || fd !== 1'b1 || fc !== 16'd3)
      $display("FAIL gapped_done: got req_seen %0d done %b count %0d, required 1 1 3",
               ok, fd, fc);
    else n_pass++;
    n_total++;
    if (n_writes - w0 != FD || exp_q.size() != 0)
      $display("FAIL gapped_writes: got %0d writes %0d pending, required %0d 0",
               n_writes - w0, exp_q.size(), FD);
    else n_pass++;
    repeat (6) tick();
  endtask

  task automatic test_invalid_id();
    int w0;
    bit req_seen = 1'b0;
    do_reset();
    w_buffer_id = 3'b011;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      trigger = (i == 7);
      s_valid = (i >= 6);
      s_data  = 16'hbeef;
      if (w_request) req_seen = 1'b1;
      tick();
    end
    trigger = 1'b0;
    s_valid = 1'b0;
    tick();
    n_total++;
    if (err !== 2'b01) $display("FAIL badid_err: got %b, required 01", err);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || req_seen)
      $display("FAIL badid_idle: got busy %b req_seen %0d, required 0 0", busy, req_seen);
    else n_pass++;
    n_total++;
    if (n_writes != w0) $display("FAIL badid_nowrite: got %0d writes, required 0", n_writes - w0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int req_cycles = 0;
    bit done_seen = 1'b0;
    do_reset();
    w_buffer_id = BUF0;
    arm = 1'b1;
    wait_armed(ok);
    send_frame(2'd0, 0, 16'h0300);
    for (int i = 0; i < 30; i++) begin
      if (w_request) req_cycles++;
      if (frame_done) done_seen = 1'b1;
      tick();
    end
    arm = 1'b0;
    n_total++;
    if (req_cycles != HT) $display("FAIL timeout_len: got %0d cycles, required %0d", req_cycles, HT);
    else n_pass++;
    n_total++;
    if (err !== 2'b10) $display("FAIL timeout_err: got %b, required 10", err);
    else n_pass++;
    n_total++;
    if (done_seen || frame_count !== 16'd0)
      $display("FAIL timeout_nodone: got done_seen %0d count %0d, required 0 0",
               done_seen, frame_count);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL timeout_writes: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    wr_t e;
    logic fd, wr;
    logic [15:0] fc;
    do_reset();
    w_buffer_id = BUF0;
    arm = 1'b1;
    wait_armed(ok);
    for (int i = 0; i < 3; i++) begin
      trigger = (i == 0);
      s_valid = 1'b1;
      s_data  = 16'h0500 + DW'(i);
      // The third write is still in the output register when reset hits.
      if (i < 2) begin
        e.addr = AW'(i);
        e.data = 16'h0500 + DW'(i);
        exp_q.push_back(e);
      end
      tick();
    end
    trigger = 1'b0;
    s_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({mem_we, w_request, busy} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL midreset_outputs: got we/req/busy %b addr %0h data %0h, required 000 0 0",
               {mem_we, w_request, busy}, mem_addr, mem_wdata);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    wait_armed(ok);
    n_total++;
    if (frame_count !== 16'd0) $display("FAIL midreset_count0: got %0d, required 0", frame_count);
    else n_pass++;
    send_frame(2'd0, 0, 16'h0600);
    wait_req(ok);
    n_total++;
    if (frame_count !== 16'd0) $display("FAIL midreset_count_pre: got %0d, required 0", frame_count);
    else n_pass++;
    handoff(BUF0, fd, wr, fc);
    arm = 1'b0;
    n_total++;
    if (fd !== 1'b1 || fc !== 16'd1)
      $display("FAIL midreset_done: got done %b count %0d, required 1 1", fd, fc);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL midreset_writes: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_controller_handoff();
    test_bank_offset();
    test_invalid_id();
    test_timeout();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
